// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result valid-ready bundle for cla_addsub_pipe
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic in_valid, in_ready, sub, cin;
  logic out_valid, out_ready, cout, ovf, zero, neg;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input in_ready, out_valid, sum, cout, ovf, zero, neg
  );
  modport slave (
    input in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor with valid/ready backpressure
module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  cla_addsub_pipe_if.slave bus
);
  localparam int GPS = WIDTH / 4 / STAGES;
  localparam int SW = 4 * GPS;
  logic adv;
  logic ovf_q, zero_q, neg_q;
  // returns {group G, group P, 4-bit sum}
  function automatic logic [5:0] grp(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g, p, c;
    g = x & y;
    p = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p, p ^ c};
  endfunction
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:SW*k] xa, xb;
    logic xc, xv, rv, rc;
    logic [SW*(k+1)-1:0] pre, ns, rs;
    logic [GPS:0] gc;
    logic [5:0] r;
    if (k == 0) begin : g_in
      assign xa = bus.a;
      assign xb = bus.sub ? ~bus.b : bus.b;
      assign xc = bus.sub | bus.cin;
      assign xv = bus.in_valid;
      assign pre = '0;
    end else begin : g_mid
      assign xa = g_stage[k-1].g_ops.ra;
      assign xb = g_stage[k-1].g_ops.rb;
      assign xc = g_stage[k-1].rc;
      assign xv = g_stage[k-1].rv;
      assign pre = {{SW{1'b0}}, g_stage[k-1].rs};
    end
    always_comb begin
      ns = pre;
      gc = '0;
      gc[0] = xc;
      r = '0;
      for (int j = 0; j < GPS; j++) begin
        r = grp(xa[SW*k+4*j +: 4], xb[SW*k+4*j +: 4], gc[j]);
        ns[SW*k+4*j +: 4] = r[3:0];
        gc[j+1] = r[5] | (r[4] & gc[j]);
      end
    end
    always_ff @(posedge clk)
      if (!rst_n) begin
        rv <= 1'b0;
        rc <= 1'b0;
        rs <= '0;
      end else if (adv) begin
        rv <= xv;
        if (xv) begin
          rc <= gc[GPS];
          rs <= ns;
        end
      end
    // upper operand bits still to be summed by later stages
    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:SW*(k+1)] ra, rb;
      always_ff @(posedge clk)
        if (rst_n && adv && xv) begin
          ra <= xa[WIDTH-1:SW*(k+1)];
          rb <= xb[WIDTH-1:SW*(k+1)];
        end
    end
  end
  assign adv = !g_stage[STAGES-1].rv | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = g_stage[STAGES-1].rv;
  assign bus.sum = g_stage[STAGES-1].rs;
  assign bus.cout = g_stage[STAGES-1].rc;
  assign bus.ovf = ovf_q;
  assign bus.zero = zero_q;
  assign bus.neg = neg_q;
  // carry into the MSB is recovered as s^a^b at that bit
  always_ff @(posedge clk)
    if (!rst_n) begin
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
    end else if (adv && g_stage[STAGES-1].xv) begin
      ovf_q <= g_stage[STAGES-1].ns[WIDTH-1] ^ g_stage[STAGES-1].xa[WIDTH-1] ^ g_stage[STAGES-1].xb[WIDTH-1] ^ g_stage[STAGES-1].gc[GPS];
      zero_q <= ~|g_stage[STAGES-1].ns;
      neg_q <= g_stage[STAGES-1].ns[WIDTH-1];
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed vectors on STAGES=1/2/8 instances plus backpressure and reset sequences
module tb_cla_addsub_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  cla_addsub_pipe_if #(.WIDTH(32)) i1 (), i2 (), i8 ();
  cla_addsub_pipe #(.WIDTH(32), .STAGES(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  cla_addsub_pipe #(.WIDTH(32), .STAGES(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  cla_addsub_pipe #(.WIDTH(32), .STAGES(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  assign i1.in_valid = in_valid; assign i1.a = a; assign i1.b = b; assign i1.sub = sub; assign i1.cin = cin; assign i1.out_ready = out_ready;
  assign i2.in_valid = in_valid; assign i2.a = a; assign i2.b = b; assign i2.sub = sub; assign i2.cin = cin; assign i2.out_ready = out_ready;
  assign i8.in_valid = in_valid; assign i8.a = a; assign i8.b = b; assign i8.sub = sub; assign i8.cin = cin; assign i8.out_ready = out_ready;
  logic ov [3], ir [3];
  logic [31:0] sm [3];
  logic [3:0] fl [3];
  assign ov[0] = i1.out_valid; assign ov[1] = i2.out_valid; assign ov[2] = i8.out_valid;
  assign ir[0] = i1.in_ready; assign ir[1] = i2.in_ready; assign ir[2] = i8.in_ready;
  assign sm[0] = i1.sum; assign sm[1] = i2.sum; assign sm[2] = i8.sum;
  assign fl[0] = {i1.cout, i1.ovf, i1.zero, i1.neg};
  assign fl[1] = {i2.cout, i2.ovf, i2.zero, i2.neg};
  assign fl[2] = {i8.cout, i8.ovf, i8.zero, i8.neg};
  int st [3] = '{1, 2, 8};
  int total = 0, passed = 0;
  typedef struct {
    logic [31:0] a, b;
    logic sub, cin;
    logic [31:0] sum;
    logic [3:0] flags;
  } vec_t;
  vec_t v [13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic run_beat(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic vs, input logic vc, input logic [31:0] es, input logic [3:0] ef);
    int lat [3], cnt [3];
    logic [31:0] gs [3];
    logic [3:0] gf [3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; cnt[d] = 0; gs[d] = '0; gf[d] = '0;
    end
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb; sub = vs; cin = vc;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (ov[d]) begin
          cnt[d]++;
          if (cnt[d] == 1) begin
            lat[d] = cyc; gs[d] = sm[d]; gf[d] = fl[d];
          end
        end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s S%0d latency", nm, st[d]), lat[d], st[d]);
      chk($sformatf("%s S%0d count", nm, st[d]), cnt[d], 1);
      chk($sformatf("%s S%0d sum", nm, st[d]), gs[d], es);
      chk($sformatf("%s S%0d flags(c,v,z,n)", nm, st[d]), gf[d], ef);
    end
  endtask
  initial begin
    int nb, got, held, extra;
    int stale [3];
    logic [31:0] hs;
    logic [3:0] hf;
    v[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b1010};
    v[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0101};
    v[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 4'b0001};
    v[3]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 4'b1000};
    v[4]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 4'b0000};
    v[5]  = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'b1010};
    v[6]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 4'b1000};
    v[7]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 4'b1100};
    v[8]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 4'b0001};
    v[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b1010};
    v[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 4'b1110};
    v[11] = '{32'h00FF00FF, 32'h0F0F0F0F, 1'b0, 1'b1, 32'h100E100F, 4'b0000};
    v[12] = '{32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 4'b0000};
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset S%0d out_valid", st[d]), ov[d], 0);
      chk($sformatf("reset S%0d in_ready", st[d]), ir[d], 1);
      chk($sformatf("reset S%0d sum", st[d]), sm[d], 0);
      chk($sformatf("reset S%0d flags", st[d]), fl[d], 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++)
      run_beat($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].sub, v[i].cin, v[i].sum, v[i].flags);
    nb = 0; got = 0; held = 0; hs = '0; hf = '0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4); in_valid = (nb < 3); a = 32'(nb + 1); b = 32'(nb + 1); sub = 1'b0; cin = 1'b0;
      #4;
      if (ov[1]) begin
        if (held != 0) begin
          chk("bp sum stable", sm[1], hs);
          chk("bp flags stable", fl[1], hf);
        end
        if (out_ready) begin
          chk($sformatf("bp result %0d", got), sm[1], 32'(2 * (got + 1)));
          got++; held = 0;
        end else begin
          chk("bp in_ready low", ir[1], 0);
          hs = sm[1]; hf = fl[1]; held = 1;
        end
      end
      if (in_valid && ir[1]) nb++;
    end
    chk("bp results delivered", got, 3);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      extra += int'(ov[1]);
    end
    chk("bp no duplicate", extra, 0);
    repeat (12) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; a = 32'd1; b = 32'd1; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    a = 32'd2; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst S%0d out_valid", st[d]), ov[d], 0);
      chk($sformatf("midrst S%0d in_ready", st[d]), ir[d], 1);
      stale[d] = 0;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) stale[d] += int'(ov[d]);
    end
    for (int d = 0; d < 3; d++) chk($sformatf("midrst S%0d stale", st[d]), stale[d], 0);
    run_beat("post-reset", 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 4'b0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
